// File: rtl/medyan_denetleyici_if.sv
// medyan_denetleyici_if
//   Handshake bundle between the window generator, the median filter stage
//   and the filtered-pixel writer.
//   Pixel width comes from the PIXEL_BIT macro (normally set by sabitler.vh).
//   It falls back to 8 when the macro is not already defined.
// Signals (named from the filter stage's point of view):
//   pencere_i        9 packed pixels; pixel k at [k*PIXEL_BIT +: PIXEL_BIT]
//   giris_gecerli_i  window valid
//   giris_hazir_o    stage can take a window
//   medyan_o         median at the output FIFO head
//   cikis_gecerli_o  medyan_o valid
//   cikis_hazir_i    consumer ready
//   tamamlanan_o     completed-window count
// Modports: slave = filter stage, master = producer/consumer side.
`ifndef PIXEL_BIT
`define PIXEL_BIT 8
`endif

interface medyan_denetleyici_if #(
  parameter int SAYAC_BIT = 16
);
  logic [9*`PIXEL_BIT-1:0] pencere_i;
  logic                    giris_gecerli_i;
  logic                    giris_hazir_o;
  logic [`PIXEL_BIT-1:0]   medyan_o;
  logic                    cikis_gecerli_o;
  logic                    cikis_hazir_i;
  logic [SAYAC_BIT-1:0]    tamamlanan_o;

  modport slave (
    input  pencere_i, giris_gecerli_i, cikis_hazir_i,
    output giris_hazir_o, medyan_o, cikis_gecerli_o, tamamlanan_o
  );

  modport master (
    output pencere_i, giris_gecerli_i, cikis_hazir_i,
    input  giris_hazir_o, medyan_o, cikis_gecerli_o, tamamlanan_o
  );
endinterface

// File: rtl/medyan_denetleyici.sv
// medyan_denetleyici
//   This module is a streaming 3x3 median filter stage. Each 9-pixel window is
//   fed serially into a medyan_birimi, which runs a fixed 10-cycle frame. The
//   window's median is returned through a 2-entry output FIFO.
// Ports:
//   clk_i   clock, rising edge
//   rst_i   asynchronous active-high reset
//   bus     medyan_denetleyici_if.slave (window in, median out, counter)
// Optional feature:
//   MEDYAN_SAYAC_EN  enables the completed-window counter on tamamlanan_o.
//                    Without this macro, tamamlanan_o is tied to 0.
// medyan_birimi is also defined here. It stores 9 samples, one per cycle.
// In the tenth cycle it presents the 5th largest sample with hazir_o high.
`ifndef PIXEL_BIT
`define PIXEL_BIT 8
`endif

module medyan_birimi (
  input  logic                  clk_i,
  input  logic                  rstn_i,   // synchronous, active-low
  input  logic [`PIXEL_BIT-1:0] sayi_i,
  output logic                  hazir_o,
  output logic [`PIXEL_BIT-1:0] medyan_o
);
  logic [`PIXEL_BIT-1:0] dizi_q [9];
  logic [3:0]            sayac_q;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      sayac_q <= '0;
    end else if (sayac_q == 4'd9) begin
      sayac_q <= '0;
    end else begin
      dizi_q[sayac_q] <= sayi_i;
      sayac_q         <= sayac_q + 4'd1;
    end
  end

  assign hazir_o = (sayac_q == 4'd9);

  // Ties are broken by index, so the ranks form a permutation of 0..8.
  // This leaves exactly one sample with rank 4.
  always_comb begin
    logic [3:0] adet;
    adet     = '0;
    medyan_o = '0;
    for (int i = 0; i < 9; i++) begin
      adet = '0;
      for (int j = 0; j < 9; j++) begin
        if ((dizi_q[j] > dizi_q[i]) || ((dizi_q[j] == dizi_q[i]) && (j < i)))
          adet = adet + 4'd1;
      end
      if (adet == 4'd4) medyan_o = dizi_q[i];
    end
  end
endmodule

// state | meaning
// BOS   | idle, median unit held in reset
// BESLE | presenting pixel k (k = 0..8) to the median unit
// SONUC | k = 9, median unit result pushed into the output FIFO
module medyan_denetleyici #(
  parameter int SAYAC_BIT = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  medyan_denetleyici_if.slave  bus
);
  localparam int PB = `PIXEL_BIT;

  typedef enum logic [1:0] {BOS, BESLE, SONUC} durum_t;

  durum_t          durum_q;
  logic [3:0]      k_q;
  logic [9*PB-1:0] tut_q, kay_q;
  logic            giris_hazir_q;   // doubles as "TUT empty"
  logic [PB-1:0]   fifo_q [2];
  logic            wr_q, rd_q;
  logic [1:0]      doluluk_q;
  logic            gecerli_q;

  logic            kabul, itme, cekme, baslat;
  logic [1:0]      doluluk_d;
  logic [9*PB-1:0] yeni_pencere;
  logic            birim_rstn, birim_hazir;
  logic [PB-1:0]   birim_sayi, birim_medyan;

  assign kabul     = bus.giris_gecerli_i && giris_hazir_q;
  assign itme      = birim_hazir;
  assign cekme     = gecerli_q && bus.cikis_hazir_i;
  assign doluluk_d = doluluk_q + {1'b0, itme} - {1'b0, cekme};

  // A window arriving this cycle counts as held, so an idle stage starts it
  // straight away. This gives the 11-cycle latency.
  assign yeni_pencere = giris_hazir_q ? bus.pencere_i : tut_q;
  assign baslat = (!giris_hazir_q || kabul) && (doluluk_d <= 2'd1) &&
                  (durum_q != BESLE);

  assign birim_rstn = !rst_i && (durum_q != BOS);
  assign birim_sayi = (durum_q == BESLE) ? kay_q[PB-1:0] : '0;

  medyan_birimi u_birim (
    .clk_i    (clk_i),
    .rstn_i   (birim_rstn),
    .sayi_i   (birim_sayi),
    .hazir_o  (birim_hazir),
    .medyan_o (birim_medyan)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      durum_q       <= BOS;
      k_q           <= '0;
      tut_q         <= '0;
      kay_q         <= '0;
      giris_hazir_q <= 1'b1;
      fifo_q[0]     <= '0;
      fifo_q[1]     <= '0;
      wr_q          <= 1'b0;
      rd_q          <= 1'b0;
      doluluk_q     <= '0;
      gecerli_q     <= 1'b0;
    end else begin
      if (kabul) tut_q <= bus.pencere_i;
      giris_hazir_q <= !((!giris_hazir_q || kabul) && !baslat);

      if (itme) begin
        fifo_q[wr_q] <= birim_medyan;
        wr_q         <= ~wr_q;
      end
      if (cekme) rd_q <= ~rd_q;
      doluluk_q <= doluluk_d;
      gecerli_q <= (doluluk_d != 2'd0);

      case (durum_q)
        BOS, SONUC: begin
          k_q <= '0;
          if (baslat) begin
            durum_q <= BESLE;
            kay_q   <= yeni_pencere;
          end else begin
            durum_q <= BOS;
          end
        end
        BESLE: begin
          kay_q <= kay_q >> PB;
          k_q   <= k_q + 4'd1;
          if (k_q == 4'd8) durum_q <= SONUC;
        end
        default: durum_q <= BOS;
      endcase
    end
  end

  assign bus.giris_hazir_o   = giris_hazir_q;
  assign bus.cikis_gecerli_o = gecerli_q;
  assign bus.medyan_o        = fifo_q[rd_q];

`ifdef MEDYAN_SAYAC_EN
  logic [SAYAC_BIT-1:0] tamamlanan_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     tamamlanan_q <= '0;
    else if (itme) tamamlanan_q <= tamamlanan_q + SAYAC_BIT'(1);
  end

  assign bus.tamamlanan_o = tamamlanan_q;
`else
  assign bus.tamamlanan_o = {SAYAC_BIT{1'b0}};
`endif
endmodule

// File: tb/tb_medyan_denetleyici.sv
module tb_medyan_denetleyici;
  localparam int SB = 4;
`ifdef MEDYAN_SAYAC_EN
  localparam int SAYAC_VAR = 1;
`else
  localparam int SAYAC_VAR = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  medyan_denetleyici_if #(.SAYAC_BIT(SB)) bus ();
  medyan_denetleyici #(.SAYAC_BIT(SB)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_ok  = 0;

  logic [7:0] q_med [$];
  int         q_cyc [$];

  always @(negedge clk) begin
    if (!rst && bus.cikis_gecerli_o && bus.cikis_hazir_i) begin
      q_med.push_back(bus.medyan_o);
      q_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] gozlenen,
                     input logic [31:0] beklenen);
    n_chk++;
    if (gozlenen === beklenen) n_ok++;
    else $display("FAIL %s: got %0d, expected %0d", tag, gozlenen, beklenen);
  endtask

  function automatic logic [71:0] pw(input logic [7:0] a0, a1, a2, a3, a4,
                                     a5, a6, a7, a8);
    return {a8, a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  // pixels b+{0,5,1,6,2,7,3,8,4}: scrambled order, median b+4
  function automatic logic [71:0] seqw(input int b);
    logic [71:0] w;
    w = '0;
    for (int k = 0; k < 9; k++) w[k*8 +: 8] = 8'(b + (k * 5) % 9);
    return w;
  endfunction

  // t = cycle whose ending edge accepted the window
  task automatic gonder(input logic [71:0] w, output int t);
    @(posedge clk); #1;
    bus.pencere_i       = w;
    bus.giris_gecerli_i = 1'b1;
    t = -1;
    for (int i = 0; i < 300 && t < 0; i++) begin
      @(negedge clk);
      if (bus.giris_hazir_o) t = cyc;
    end
    @(posedge clk); #1;
    bus.giris_gecerli_i = 1'b0;
    if (t < 0) chk("kabul_zaman_asimi", 0, 1);
  endtask

  task automatic temizle();
    q_med.delete();
    q_cyc.delete();
  endtask

  initial begin
    int t0, t1, t2;
    logic [71:0] w;

    bus.pencere_i       = '0;
    bus.giris_gecerli_i = 1'b0;
    bus.cikis_hazir_i   = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_giris_hazir", bus.giris_hazir_o, 1);
    chk("rst_cikis_gecerli", bus.cikis_gecerli_o, 0);
    chk("rst_medyan", bus.medyan_o, 0);
    chk("rst_tamamlanan", bus.tamamlanan_o, 0);
    rst = 1'b0;

    // single window, latency 11
    gonder(pw(1, 2, 3, 4, 5, 6, 7, 8, 9), t0);
    repeat (20) @(negedge clk);
    chk("t1_adet", q_med.size(), 1);
    if (q_med.size() >= 1) begin
      chk("t1_medyan", q_med[0], 5);
      chk("t1_gecikme", q_cyc[0] - t0, 11);
    end
    chk("t1_tamamlanan", bus.tamamlanan_o, SAYAC_VAR);

    // back-to-back
    temizle();
    gonder(pw(7, 7, 7, 3, 3, 3, 9, 9, 9), t0);
    gonder('0, t1);
    w = {9{8'hFF}};
    gonder(w, t2);
    repeat (40) @(negedge clk);
    chk("t2_adet", q_med.size(), 3);
    if (q_med.size() >= 3) begin
      chk("t2_medyan0", q_med[0], 7);
      chk("t2_medyan1", q_med[1], 0);
      chk("t2_medyan2", q_med[2], 255);
      chk("t2_gecikme", q_cyc[0] - t0, 11);
      chk("t2_aralik01", q_cyc[1] - q_cyc[0], 10);
      chk("t2_aralik12", q_cyc[2] - q_cyc[1], 10);
    end

    // backpressure
    temizle();
    bus.cikis_hazir_i = 1'b0;
    gonder(seqw(10), t0);
    gonder(seqw(20), t1);
    gonder(seqw(30), t2);
    bus.pencere_i       = seqw(40);
    bus.giris_gecerli_i = 1'b1;
    repeat (30) @(negedge clk);
    chk("t3_giris_hazir", bus.giris_hazir_o, 0);
    chk("t3_cikis_gecerli", bus.cikis_gecerli_o, 1);
    chk("t3_bas_medyan", bus.medyan_o, 14);
    @(posedge clk); #1;
    bus.cikis_hazir_i = 1'b1;
    gonder(seqw(40), t0);
    repeat (40) @(negedge clk);
    chk("t3_adet", q_med.size(), 4);
    if (q_med.size() >= 4) begin
      chk("t3_medyan0", q_med[0], 14);
      chk("t3_medyan1", q_med[1], 24);
      chk("t3_medyan2", q_med[2], 34);
      chk("t3_medyan3", q_med[3], 44);
    end

    // pop in the same cycle as a push, occupancy 1
    temizle();
    bus.cikis_hazir_i = 1'b0;
    gonder(seqw(50), t0);
    repeat (15) @(negedge clk);
    chk("t4_tek_dolu", bus.cikis_gecerli_o, 1);
    gonder(seqw(60), t1);
    while (cyc < t1 + 9) @(negedge clk);
    @(posedge clk); #1;
    bus.cikis_hazir_i = 1'b1;
    repeat (6) @(negedge clk);
    chk("t4_adet", q_med.size(), 2);
    if (q_med.size() >= 2) begin
      chk("t4_medyan0", q_med[0], 54);
      chk("t4_zaman0", q_cyc[0] - t1, 10);
      chk("t4_medyan1", q_med[1], 64);
      chk("t4_zaman1", q_cyc[1] - t1, 11);
    end
    chk("t4_bos", bus.cikis_gecerli_o, 0);

    // reset mid-frame at k=4, with a second window buffered
    temizle();
    gonder(seqw(100), t0);
    gonder(seqw(110), t1);
    while (cyc < t0 + 5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5_rst_giris_hazir", bus.giris_hazir_o, 1);
    chk("t5_rst_cikis_gecerli", bus.cikis_gecerli_o, 0);
    @(negedge clk);
    rst = 1'b0;
    gonder(pw(9, 1, 8, 2, 7, 3, 6, 4, 5), t2);
    repeat (30) @(negedge clk);
    chk("t5_adet", q_med.size(), 1);
    if (q_med.size() >= 1) begin
      chk("t5_medyan", q_med[0], 5);
      chk("t5_gecikme", q_cyc[0] - t2, 11);
    end

    // counter wrap: 17 windows into a 4-bit counter
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    temizle();
    for (int i = 0; i < 17; i++) gonder(seqw(i), t0);
    repeat (40) @(negedge clk);
    chk("t6_adet", q_med.size(), 17);
    if (q_med.size() >= 17) chk("t6_son_medyan", q_med[16], 20);
    chk("t6_tamamlanan", bus.tamamlanan_o, SAYAC_VAR);

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end
endmodule
